rv32i_lsu: RTL and testbench
============================

# rv32i_lsu

Parametrised load/store unit for the next-generation RV32I core. It replaces the single-cycle core's direct bus wiring (address = ALU output, fixed-word store data, no wait states) with a handshaked memory stage. The stage adds byte-lane alignment, byte enables, load sign/zero extension, misalignment detection and a bus-timeout error. It sits between the core's execute stage (ALU result as address, rs2 as store data) and the data bus, and stalls the core while an access is outstanding.

## Interface
- XLEN, 32: data width; 32 or 64.
- ADDR_W, 32: byte-address width.
- TIMEOUT, 16: cycles in ACCESS without `bus_ack` before a timeout error; must be ≥ 2.

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a load/store.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only).
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 unsupported size.
- stall  out  1  `req_valid & ~rsp_valid`; holds the core's PC and decode.
- bus_addr  out  ADDR_W  address with low log2(XLEN/8) bits cleared.
- bus_wrdata  out  XLEN  lane-shifted store data.
- bus_be  out  XLEN/8  byte enables.
- bus_wren, bus_rden  out  1  access strobes, held until ack or timeout.
- bus_ack  in  1  slave completes the access this cycle.
- bus_rddata  in  XLEN  read data, valid with `bus_ack`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch the request and check it:
    - size 3 with XLEN=32 → error 3.
    - half with addr[0] ≠ 0, word with addr[1:0] ≠ 0, or dword with addr[2:0] ≠ 0 → error 1.
    - Any error → RESP with no bus activity.
    - Otherwise → ACCESS.
- **ACCESS**
  - Strobe, `bus_addr`, `bus_wrdata` and `bus_be` are registered and stable for the whole state.
  - off = addr[log2(XLEN/8)-1:0].
  - `bus_be` = ((1 << (1 << size)) − 1) << off.
  - `bus_wrdata` = req_wdata << (8·off).
  - Wait counter starts at 0 and increments each cycle without ack.
  - On `bus_ack`:
    - Load: capture bus_rddata >> (8·off), truncate to the size, then sign-extend (or zero-extend if `req_unsigned`) into the rdata register.
    - Go to RESP.
  - If counter == TIMEOUT−1 and no ack → RESP with error 2.
  - Ack in the same cycle as the timeout: ack wins, no error.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle with `rsp_rdata` and `rsp_err`, then → IDLE.
  - Strobes are 0.
- A request in IDLE is accepted the same cycle; back-to-back requests are accepted on the cycle after RESP.
- `bus_ack` outside ACCESS is ignored.
- `req_*` changes after acceptance are ignored; the request is latched.

## Timing
- Reset (sync): state IDLE; every output register 0.
  - `req_ready` = 1 after reset.
  - `stall` follows `req_valid`.
- Reset mid-ACCESS: strobes drop at that edge, no `rsp_valid` is produced, and the pending access is abandoned.
- Aligned access, acceptance at cycle 0:
  - Strobe high from cycle 1.
  - Ack at cycle k ≥ 1 → `rsp_valid` at cycle k+1.
  - Minimum latency 2 cycles.
- Error on acceptance at cycle 0 → `rsp_valid` at cycle 1, no strobe.
- Timeout: strobe high during cycles 1..TIMEOUT, `rsp_valid` with error 2 at cycle TIMEOUT+1.
- `stall` is combinational and drops in the `rsp_valid` cycle, so the core advances on the next edge.

## Structure
- Package `lsu_pkg` holds:
  - `lsu_size_t` enum (BYTE, HALF, WORD, DWORD).
  - `lsu_err_t` enum (NONE, MISALIGNED, TIMEOUT, BADSIZE).
  - `lsu_state_t` enum (IDLE, ACCESS, RESP).
  - Function `lsu_be(size, off)`.
- Sub-module `lsu_lane_align`: purely combinational.
  - Store shift and BE generation.
  - Load shift and extension.
  - Parametrised by XLEN.
- FSM, counter and latches live in `rv32i_lsu`.

## Test plan
- XLEN=32, SB addr 0x1003 data 0x000000A5, ack at cycle 1:
  - `bus_addr` 0x1000, `bus_be` 4'b1000, `bus_wrdata` 0xA5000000.
  - `rsp_valid` at cycle 2, err 0.
- LH addr 0x2002, bus_rddata 0x8001_1234, ack after 3 wait cycles:
  - `rsp_rdata` 0xFFFF8001 at cycle 5.
  - Same with LHU → 0x00008001.
- LW addr 0x3001:
  - `rsp_valid` at cycle 1, err 1.
  - `bus_rden` never asserted.
- LW addr 0x4000, TIMEOUT=16, no ack:
  - `bus_rden` high during cycles 1–16, err 2 at cycle 17.
  - Repeat with ack at cycle 16 → err 0.
- `rst` asserted at cycle 2 of a pending SW:
  - Strobes 0 from cycle 3, `rsp_valid` never pulses.
  - Next request accepted normally.
- XLEN=64:
  - LD addr 0x8, rddata 0x8000_0000_0000_0001, ack at cycle 1 → `rsp_rdata` 0x8000000000000001 at cycle 2, err 0.
  - LWU addr 0x4, rddata 0xFFFF_FFFF_0000_0000 → `bus_be` 8'hF0, `rsp_rdata` 0x00000000FFFFFFFF.
  - On XLEN=32, req_size 3 → err 3.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and byte-enable helper for the RV32I load/store unit.
package lsu_pkg;

  localparam int unsigned MAX_BE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } lsu_size_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_TIMEOUT    = 2'd2,
    ERR_BADSIZE    = 2'd3
  } lsu_err_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_t;

  // Contiguous 2^size byte mask moved up to the byte offset within the bus word.
  function automatic logic [MAX_BE_W-1:0] lsu_be(input lsu_size_t size, input logic [2:0] off);
    logic [MAX_BE_W-1:0] mask;
    case (size)
      SZ_BYTE: mask = 8'h01;
      SZ_HALF: mask = 8'h03;
      SZ_WORD: mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << off;
  endfunction

endpackage

// File: rtl/rv32i_lsu_lane_align.sv
// Combinational byte-lane steering: store shift and byte enables, load shift and extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned BE_W  = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(BE_W)
) (
  input  lsu_size_t        i_st_size,
  input  logic [OFF_W-1:0] i_st_off,
  input  logic [XLEN-1:0]  i_st_wdata,
  output logic [BE_W-1:0]  o_st_be_c,
  output logic [XLEN-1:0]  o_st_wdata_c,
  input  lsu_size_t        i_ld_size,
  input  logic [OFF_W-1:0] i_ld_off,
  input  logic             i_ld_unsigned,
  input  logic [XLEN-1:0]  i_ld_rdata,
  output logic [XLEN-1:0]  o_ld_data_c
);

  logic [XLEN-1:0] w_ld_sh;
  logic [63:0]     w_ext;
  logic            w_sign;

  assign o_st_be_c    = BE_W'(lsu_be(i_st_size, 3'(i_st_off)));
  assign o_st_wdata_c = i_st_wdata << {i_st_off, 3'b000};
  assign w_ld_sh      = i_ld_rdata >> {i_ld_off, 3'b000};

  // Extension is built at 64 bits so no replication width depends on XLEN.
  always_comb begin
    w_sign = 1'b0;
    w_ext  = 64'(w_ld_sh);
    case (i_ld_size)
      SZ_BYTE: begin
        w_sign = ~i_ld_unsigned & w_ld_sh[7];
        w_ext  = {{56{w_sign}}, w_ld_sh[7:0]};
      end
      SZ_HALF: begin
        w_sign = ~i_ld_unsigned & w_ld_sh[15];
        w_ext  = {{48{w_sign}}, w_ld_sh[15:0]};
      end
      SZ_WORD: begin
        w_sign = ~i_ld_unsigned & w_ld_sh[31];
        w_ext  = {{32{w_sign}}, w_ld_sh[31:0]};
      end
      default: w_ext = 64'(w_ld_sh);
    endcase
  end

  assign o_ld_data_c = XLEN'(w_ext);

endmodule

// File: rtl/rv32i_lsu.sv
// Handshaked load/store memory stage: latches a core request, drives the data bus
// with aligned strobes/enables, and returns extended load data or an error code.
module rv32i_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              stall,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wrdata,
  output logic [XLEN/8-1:0] bus_be,
  output logic              bus_wren,
  output logic              bus_rden,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rddata
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       r_state;
  lsu_state_t       w_state_nxt;
  lsu_size_t        r_size;
  logic [OFF_W-1:0] r_off;
  logic             r_we;
  logic             r_unsigned;
  logic [CNT_W-1:0] r_cnt;
  lsu_err_t         r_err;
  logic [XLEN-1:0]  r_rdata;
  logic [XLEN-1:0]  r_wrdata;
  logic [BE_W-1:0]  r_be;
  logic [ADDR_W-1:0] r_addr;
  logic             r_wren;
  logic             r_rden;

  lsu_size_t        w_req_size;
  logic [OFF_W-1:0] w_req_off;
  lsu_err_t         w_req_err;
  logic [BE_W-1:0]  w_st_be;
  logic [XLEN-1:0]  w_st_wdata;
  logic [XLEN-1:0]  w_ld_data;
  logic             w_timeout;

  assign w_req_size = lsu_size_t'(req_size);
  assign w_req_off  = req_addr[OFF_W-1:0];
  assign w_timeout  = (r_cnt == CNT_LAST);

  // Request screening: unsupported size first, then natural alignment.
  always_comb begin
    w_req_err = ERR_NONE;
    case (w_req_size)
      SZ_HALF:  if (req_addr[0]) w_req_err = ERR_MISALIGNED;
      SZ_WORD:  if (|req_addr[1:0]) w_req_err = ERR_MISALIGNED;
      SZ_DWORD: begin
        if (XLEN == 32)          w_req_err = ERR_BADSIZE;
        else if (|req_addr[2:0]) w_req_err = ERR_MISALIGNED;
      end
      default: w_req_err = ERR_NONE;
    endcase
  end

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .i_st_size     (w_req_size),
    .i_st_off      (w_req_off),
    .i_st_wdata    (req_wdata),
    .o_st_be_c     (w_st_be),
    .o_st_wdata_c  (w_st_wdata),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_unsigned),
    .i_ld_rdata    (bus_rddata),
    .o_ld_data_c   (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (w_req_err == ERR_NONE) ? S_ACCESS : S_RESP;
      end
      S_ACCESS: if (bus_ack || w_timeout) w_state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, bus drive registers, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_size     <= SZ_BYTE;
      r_off      <= '0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_cnt      <= '0;
      r_err      <= ERR_NONE;
      r_rdata    <= '0;
      r_wrdata   <= '0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wren     <= 1'b0;
      r_rden     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_size     <= w_req_size;
            r_off      <= w_req_off;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_cnt      <= '0;
            r_err      <= w_req_err;
            r_rdata    <= '0;
            r_addr     <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            r_be       <= w_st_be;
            r_wrdata   <= w_st_wdata;
            if (w_req_err == ERR_NONE) begin
              r_wren <= req_we;
              r_rden <= ~req_we;
            end
          end
        end
        S_ACCESS: begin
          if (bus_ack) begin
            r_wren <= 1'b0;
            r_rden <= 1'b0;
            if (!r_we) r_rdata <= w_ld_data;
          end else if (w_timeout) begin
            r_wren <= 1'b0;
            r_rden <= 1'b0;
            r_err  <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign bus_addr   = r_addr;
  assign bus_wrdata = r_wrdata;
  assign bus_be     = r_be;
  assign bus_wren   = r_wren;
  assign bus_rden   = r_rden;
  assign stall      = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: one XLEN=32 (TIMEOUT=16) and one XLEN=64 (TIMEOUT=4) instance,
// directed vector table, reset-abort sequence and randomized traffic against a byte-level model.
module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel64;
  logic        req_valid, req_we, req_unsigned, bus_ack;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, bus_rddata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic        v32, v64, a32, a64;
  logic        d32_ready, d32_rsp, d32_stall, d32_wren, d32_rden;
  logic        d64_ready, d64_rsp, d64_stall, d64_wren, d64_rden;
  logic [1:0]  d32_err, d64_err;
  logic [31:0] d32_rdata, d32_wr, d32_addr, d64_addr;
  logic [63:0] d64_rdata, d64_wr;
  logic [3:0]  d32_be;
  logic [7:0]  d64_be;

  assign v32 = req_valid & ~sel64;
  assign v64 = req_valid & sel64;
  assign a32 = bus_ack & ~sel64;
  assign a64 = bus_ack & sel64;

  rv32i_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(16)) u_d32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(d32_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .rsp_valid(d32_rsp), .rsp_rdata(d32_rdata),
    .rsp_err(d32_err), .stall(d32_stall), .bus_addr(d32_addr), .bus_wrdata(d32_wr),
    .bus_be(d32_be), .bus_wren(d32_wren), .bus_rden(d32_rden), .bus_ack(a32),
    .bus_rddata(bus_rddata[31:0])
  );

  rv32i_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u_d64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_ready(d64_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(d64_rsp), .rsp_rdata(d64_rdata),
    .rsp_err(d64_err), .stall(d64_stall), .bus_addr(d64_addr), .bus_wrdata(d64_wr),
    .bus_be(d64_be), .bus_wren(d64_wren), .bus_rden(d64_rden), .bus_ack(a64),
    .bus_rddata(bus_rddata)
  );

  logic        o_ready, o_rsp, o_stall, o_wren, o_rden;
  logic [1:0]  o_err;
  logic [31:0] o_addr;
  logic [63:0] o_rdata, o_wr;
  logic [7:0]  o_be;

  assign o_ready = sel64 ? d64_ready : d32_ready;
  assign o_rsp   = sel64 ? d64_rsp   : d32_rsp;
  assign o_stall = sel64 ? d64_stall : d32_stall;
  assign o_wren  = sel64 ? d64_wren  : d32_wren;
  assign o_rden  = sel64 ? d64_rden  : d32_rden;
  assign o_err   = sel64 ? d64_err   : d32_err;
  assign o_addr  = sel64 ? d64_addr  : d32_addr;
  assign o_rdata = sel64 ? d64_rdata : {32'h0, d32_rdata};
  assign o_wr    = sel64 ? d64_wr    : {32'h0, d32_wr};
  assign o_be    = sel64 ? d64_be    : {4'h0, d32_be};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: byte-by-byte lane placement and extension from the access rules.
  function automatic void model(input bit s64, input bit we, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rddata, input int ack,
                                output logic [7:0] be, output logic [63:0] wr,
                                output logic [63:0] rd, output logic [1:0] err, output int cyc);
    int nb, tmo, n, off;
    nb  = s64 ? 8 : 4;
    tmo = s64 ? 4 : 16;
    n   = 1 << size;
    off = int'(addr % 32'(nb));
    be = '0; wr = '0; rd = '0;
    if (!s64 && size == 2'd3) begin err = 2'd3; cyc = 1; end
    else if (addr % 32'(n) != 0) begin err = 2'd1; cyc = 1; end
    else if (ack < 1 || ack > tmo) begin err = 2'd2; cyc = tmo + 1; end
    else begin err = 2'd0; cyc = ack + 1; end
    if (err == 2'd0 || err == 2'd2)
      for (int i = 0; i < n; i++) be[off+i] = 1'b1;
    for (int i = off; i < nb; i++) wr[8*i +: 8] = wdata[8*(i-off) +: 8];
    if (err == 2'd0 && !we) begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = rddata[8*(off+i) +: 8];
      if (!uns && rd[8*n-1])
        for (int i = n; i < nb; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  task automatic run_txn(input string name, input bit s64, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rddata, input int ack, input logic [7:0] ebe,
                         input logic [63:0] ewr, input logic [63:0] erd,
                         input logic [1:0] eerr, input int ecyc);
    int  tmo, nb, got_cyc;
    bit  done, strobe;
    logic [63:0] grd;
    logic [1:0]  gerr;
    tmo    = s64 ? 4 : 16;
    nb     = s64 ? 8 : 4;
    strobe = (eerr == 2'd0 || eerr == 2'd2);
    done = 1'b0; got_cyc = -1; grd = '0; gerr = '0;
    @(negedge clk);
    sel64 = s64;
    #1;
    chk({name, ".ready"}, 64'(o_ready), 64'd1);
    chk({name, ".idle_rsp"}, 64'(o_rsp), 64'd0);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    bus_ack = 1'b1;
    bus_rddata = {$urandom, $urandom};
    #1;
    chk({name, ".stall0"}, 64'(o_stall), 64'd1);
    for (int c = 1; c <= tmo + 3 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = {$urandom, $urandom};
      end
      if (o_rsp) begin
        done = 1'b1; got_cyc = c; grd = o_rdata; gerr = o_err;
        chk({name, ".stall_rsp"}, 64'(o_stall), 64'd0);
        chk({name, ".strobe_rsp"}, 64'({o_rden, o_wren}), 64'd0);
        req_valid = 1'b0;
        bus_ack = 1'b0;
      end else begin
        chk({name, ".rden"}, 64'(o_rden), 64'(strobe & ~we));
        chk({name, ".wren"}, 64'(o_wren), 64'(strobe & we));
        chk({name, ".ready_busy"}, 64'(o_ready), 64'd0);
        if (c == 1 && strobe) begin
          chk({name, ".addr"}, 64'(o_addr), 64'(addr & ~32'(nb - 1)));
          chk({name, ".be"}, 64'(o_be), 64'(ebe));
          if (we) chk({name, ".wrdata"}, o_wr, ewr);
        end
        bus_ack    = (c == ack);
        bus_rddata = (c == ack) ? rddata : {$urandom, $urandom};
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL %s.no_rsp: got none expected rsp_valid at cycle %0d", name, ecyc);
      req_valid = 1'b0;
      bus_ack = 1'b0;
    end else begin
      chk({name, ".cycle"}, 64'(got_cyc), 64'(ecyc));
      chk({name, ".err"}, 64'(gerr), 64'(eerr));
      chk({name, ".rdata"}, grd, erd);
    end
  endtask

  typedef struct {
    string       name;
    bit          s64;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rddata;
    int          ack;
    logic [7:0]  be;
    logic [63:0] wr;
    logic [63:0] rd;
    logic [1:0]  err;
    int          cyc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [7:0]  mbe;
    logic [63:0] mwr, mrd;
    logic [1:0]  merr;
    int          mcyc;

    tbl[0]  = '{"sb",      0, 1, 2'd0, 0, 32'h1003, 64'hA5, 64'h0, 1, 8'h08, 64'hA500_0000, 64'h0, 2'd0, 2};
    tbl[1]  = '{"lh",      0, 0, 2'd1, 0, 32'h2002, 64'h0, 64'h8001_1234, 4, 8'h0C, 64'h0, 64'h0000_0000_FFFF_8001, 2'd0, 5};
    tbl[2]  = '{"lhu",     0, 0, 2'd1, 1, 32'h2002, 64'h0, 64'h8001_1234, 4, 8'h0C, 64'h0, 64'h0000_0000_0000_8001, 2'd0, 5};
    tbl[3]  = '{"lw_mis",  0, 0, 2'd2, 0, 32'h3001, 64'h0, 64'h0, 1, 8'h00, 64'h0, 64'h0, 2'd1, 1};
    tbl[4]  = '{"lw_tmo",  0, 0, 2'd2, 0, 32'h4000, 64'h0, 64'h0, 0, 8'h0F, 64'h0, 64'h0, 2'd2, 17};
    tbl[5]  = '{"lw_ack16",0, 0, 2'd2, 0, 32'h4000, 64'h0, 64'h1234_5678, 16, 8'h0F, 64'h0, 64'h1234_5678, 2'd0, 17};
    tbl[6]  = '{"badsize", 0, 0, 2'd3, 0, 32'h0000, 64'h0, 64'h0, 1, 8'h00, 64'h0, 64'h0, 2'd3, 1};
    tbl[7]  = '{"ld",      1, 0, 2'd3, 0, 32'h0008, 64'h0, 64'h8000_0000_0000_0001, 1, 8'hFF, 64'h0, 64'h8000_0000_0000_0001, 2'd0, 2};
    tbl[8]  = '{"lwu",     1, 0, 2'd2, 1, 32'h0004, 64'h0, 64'hFFFF_FFFF_0000_0000, 1, 8'hF0, 64'h0, 64'h0000_0000_FFFF_FFFF, 2'd0, 2};
    tbl[9]  = '{"lw64",    1, 0, 2'd2, 0, 32'h0004, 64'h0, 64'hFFFF_FFFF_0000_0000, 1, 8'hF0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 2};
    tbl[10] = '{"sh",      0, 1, 2'd1, 0, 32'h0002, 64'hBEEF, 64'h0, 2, 8'h0C, 64'hBEEF_0000, 64'h0, 2'd0, 3};
    tbl[11] = '{"sb64",    1, 1, 2'd0, 0, 32'h0005, 64'h7F, 64'h0, 1, 8'h20, 64'h0000_7F00_0000_0000, 64'h0, 2'd0, 2};
    tbl[12] = '{"ld_mis",  1, 0, 2'd3, 0, 32'h0004, 64'h0, 64'h0, 1, 8'h00, 64'h0, 64'h0, 2'd1, 1};
    tbl[13] = '{"lb_tmo64",1, 0, 2'd0, 0, 32'h0003, 64'h0, 64'h0, 0, 8'h08, 64'h0, 64'h0, 2'd2, 5};
    tbl[14] = '{"lb",      0, 0, 2'd0, 0, 32'h0001, 64'h0, 64'h0000_8000, 3, 8'h02, 64'h0, 64'h0000_0000_FFFF_FF80, 2'd0, 4};

    rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_rddata = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel64 = s[0];
      #1;
      chk("rst.ready", 64'(o_ready), 64'd1);
      chk("rst.rsp", 64'(o_rsp), 64'd0);
      chk("rst.strobes", 64'({o_rden, o_wren}), 64'd0);
      chk("rst.err", 64'(o_err), 64'd0);
      chk("rst.rdata", o_rdata, 64'd0);
      chk("rst.be", 64'(o_be), 64'd0);
      chk("rst.addr", 64'(o_addr), 64'd0);
      chk("rst.stall", 64'(o_stall), 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 15; i++)
      run_txn(tbl[i].name, tbl[i].s64, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
              tbl[i].wdata, tbl[i].rddata, tbl[i].ack, tbl[i].be, tbl[i].wr, tbl[i].rd,
              tbl[i].err, tbl[i].cyc);

    // Reset while an SW is waiting for ack: strobes drop, no response, next request works.
    @(negedge clk);
    sel64 = 1'b0;
    #1;
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
    req_wdata = 64'hCAFE_F00D; req_valid = 1'b1;
    @(negedge clk);
    chk("rstmid.wren1", 64'(o_wren), 64'd1);
    @(negedge clk);
    chk("rstmid.wren2", 64'(o_wren), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.wren3", 64'(o_wren), 64'd0);
    chk("rstmid.rden3", 64'(o_rden), 64'd0);
    chk("rstmid.rsp3", 64'(o_rsp), 64'd0);
    chk("rstmid.ready3", 64'(o_ready), 64'd1);
    req_valid = 1'b0;
    bus_ack = 1'b1;
    for (int c = 4; c < 8; c++) begin
      @(negedge clk);
      chk("rstmid.rsp_quiet", 64'(o_rsp), 64'd0);
      chk("rstmid.strobe_quiet", 64'({o_rden, o_wren}), 64'd0);
    end
    bus_ack = 1'b0;
    run_txn("after_rst", 0, 0, 2'd2, 0, 32'h0000_0040, 64'h0, 64'h8765_4321, 2,
            8'h0F, 64'h0, 64'h0000_0000_8765_4321, 2'd0, 3);

    for (int i = 0; i < 80; i++) begin
      bit          s, w, u;
      logic [1:0]  sz;
      logic [31:0] ad;
      logic [63:0] wd, rdd;
      int          ack, tmo;
      s   = 1'($urandom);
      w   = 1'($urandom);
      u   = 1'($urandom);
      sz  = 2'($urandom);
      ad  = 32'($urandom % 4096);
      if ($urandom % 3 != 0) ad = ad & ~(32'(1 << sz) - 32'd1);
      wd  = {$urandom, $urandom};
      rdd = {$urandom, $urandom};
      tmo = s ? 4 : 16;
      ack = int'($urandom_range(0, tmo + 1));
      model(s, w, sz, u, ad, wd, rdd, ack, mbe, mwr, mrd, merr, mcyc);
      run_txn($sformatf("rnd%0d", i), s, w, sz, u, ad, wd, rdd, ack, mbe, mwr, mrd, merr, mcyc);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
